// File: rtl/alu_mdu_if.sv
// Request/response bundle for alu_mdu: operand handshake, flush and held result.
interface alu_mdu_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    ALUResult;
    logic                     illegal;

    modport master (
        output in_valid, Operation, SrcA, SrcB, flush, out_ready,
        input  in_ready, out_valid, ALUResult, illegal
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, flush, out_ready,
        output in_ready, out_valid, ALUResult, illegal
    );
endinterface

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus iterative shift-add multiplier and restoring divider.
// Define ALU_MDU_DIV_EN to build the divider (codes 14-17); otherwise they report illegal.
module alu_mdu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_mdu_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

    state_e         state_q, state_d;
    logic [1:0]     sub_q, sub_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   res_q, res_d;
    logic           ill_q, ill_d;
`ifdef ALU_MDU_DIV_EN
    logic [W-1:0]   a_q, a_d;
    logic           bz_q, bz_d;
    logic [W:0]     div_trial, div_diff;
    logic [2*W-1:0] div_next;
    logic [W-1:0]   div_val, div_fix;
`endif

    logic [OPCODE_LENGTH-1:0] op;
    logic [CW-1:0]  shamt;
    logic [W-1:0]   alu_res, abs_a, abs_b;
    logic           cmp, is_mul, is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next, mul_fin;

    assign op    = bus.Operation;
    assign shamt = bus.SrcB[CW-1:0];

    always_comb begin
        cmp     = 1'b0;
        alu_res = '0;
        case (op[3:0])
            4'h0: alu_res = bus.SrcA & bus.SrcB;
            4'h1: alu_res = bus.SrcA | bus.SrcB;
            4'h2: alu_res = bus.SrcA + bus.SrcB;
            4'h3: alu_res = bus.SrcA ^ bus.SrcB;
            4'h4: alu_res = bus.SrcA << shamt;
            4'h5: alu_res = bus.SrcA >> shamt;
            4'h6: alu_res = bus.SrcA - bus.SrcB;
            4'h7: alu_res = $signed(bus.SrcA) >>> shamt;
            4'h8: cmp = (bus.SrcA == bus.SrcB);
            4'h9: cmp = ($signed(bus.SrcA) <  $signed(bus.SrcB));
            4'hA: cmp = ($signed(bus.SrcA) >= $signed(bus.SrcB));
            4'hB: cmp = (bus.SrcA != bus.SrcB);
            4'hC: cmp = ($signed(bus.SrcA) <  $signed(bus.SrcB));
            4'hD: cmp = (bus.SrcA < bus.SrcB);
            4'hE: cmp = (bus.SrcA >= bus.SrcB);
            default: cmp = 1'b1;
        endcase
        if (op[3:0] >= 4'h8) alu_res = {{(W-1){1'b0}}, cmp};
    end

    // Both iterative units work on magnitudes; the sign is reapplied at the end.
    assign is_mul = op[4] && (op[3:2] == 2'b00);
`ifdef ALU_MDU_DIV_EN
    assign is_div = op[4] && (op[3:2] == 2'b01);
`else
    assign is_div = 1'b0;
`endif
    assign sgn_a = is_mul ? op[0] : (is_div && !op[0]);
    assign sgn_b = is_mul ? (op[1:0] == 2'b01) : (is_div && !op[0]);
    assign neg_a = sgn_a && bus.SrcA[W-1];
    assign neg_b = sgn_b && bus.SrcB[W-1];
    assign abs_a = neg_a ? ('0 - bus.SrcA) : bus.SrcA;
    assign abs_b = neg_b ? ('0 - bus.SrcB) : bus.SrcB;

    assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, prod_q[W-1:1]};
    assign mul_fin  = neg_q ? ('0 - mul_next) : mul_next;

`ifdef ALU_MDU_DIV_EN
    assign div_trial = prod_q[2*W-1:W-1];
    assign div_diff  = div_trial - {1'b0, mag_q};
    assign div_next  = div_diff[W] ? {div_trial[W-1:0], prod_q[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  prod_q[W-2:0], 1'b1};
    assign div_val   = sub_q[1] ? prod_q[2*W-1:W] : prod_q[W-1:0];
    // Divide by zero bypasses sign correction: quotient all-ones, remainder = dividend.
    assign div_fix   = bz_q ? (sub_q[1] ? a_q : '1)
                            : (neg_q ? ('0 - div_val) : div_val);
`endif

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ill_d   = ill_q;
`ifdef ALU_MDU_DIV_EN
        a_d     = a_q;
        bz_d    = bz_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                sub_d = op[1:0];
                cnt_d = '0;
                ill_d = op[4] && !is_mul && !is_div;
                if (is_mul) begin
                    state_d = MUL;
                    mag_d   = abs_a;
                    prod_d  = {{W{1'b0}}, abs_b};
                    neg_d   = neg_a ^ neg_b;
                end
`ifdef ALU_MDU_DIV_EN
                else if (is_div) begin
                    state_d = DIV;
                    mag_d   = abs_b;
                    prod_d  = {{W{1'b0}}, abs_a};
                    neg_d   = op[1] ? neg_a : (neg_a ^ neg_b);
                    a_d     = bus.SrcA;
                    bz_d    = (bus.SrcB == '0);
                end
`endif
                else begin
                    state_d = DONE;
                    res_d   = op[4] ? '0 : alu_res;
                end
            end
            MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    res_d   = (sub_q == 2'b00) ? mul_fin[W-1:0] : mul_fin[2*W-1:W];
                end
            end
`ifdef ALU_MDU_DIV_EN
            DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                res_d   = div_fix;
            end
`endif
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sub_q   <= '0;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            a_q     <= '0;
            bz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
`ifdef ALU_MDU_DIV_EN
            a_q     <= a_d;
            bz_q    <= bz_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.ALUResult = res_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at DATA_WIDTH=32; divider vectors only when ALU_MDU_DIV_EN is defined.
module tb_alu_mdu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_mdu_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) bus();

    alu_mdu #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request; returns at the negedge one cycle after accept with inputs scrambled.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("in_ready before issue", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.Operation = 5'h1F;
        bus.SrcA      = ~a;
        bus.SrcB      = ~b;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_ill, input int exp_lat);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, bus.ALUResult, exp_res);
        check({tag, " illegal"}, bus.illegal, exp_ill);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " drained"}, bus.out_valid, 0);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    task automatic flush_test(input string tag, input logic [4:0] op);
        issue(op, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check({tag, " in_ready after flush"}, bus.in_ready, 1);
        check({tag, " out_valid after flush"}, bus.out_valid, 0);
        expect_silence({tag, " no late result"}, 40);
        run_op({tag, " TRUE after flush"}, 5'h0F, 32'd0, 32'd0, 32'd1, 1'b0, 1);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.Operation = '0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset out_valid", bus.out_valid, 0);
        check("reset ALUResult", bus.ALUResult, 0);
        check("reset illegal", bus.illegal, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", bus.in_ready, 1);

        run_op("ADD wrap",  5'h02, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1);
        run_op("LT signed", 5'h09, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1);
        run_op("SLTU",      5'h0D, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
        run_op("AND",       5'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
        run_op("OR",        5'h01, 32'h0F0000F0, 32'h00F0000F, 32'h0FF000FF, 1'b0, 1);
        run_op("XOR",       5'h03, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1);
        run_op("SLL low5",  5'h04, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1);
        run_op("SRL",       5'h05, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1);
        run_op("SUB wrap",  5'h06, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1);
        run_op("SRA",       5'h07, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1);
        run_op("EQ",        5'h08, 32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1);
        run_op("GE signed", 5'h0A, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1);
        run_op("NE",        5'h0B, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1);
        run_op("SLT",       5'h0C, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, 1);
        run_op("GEU",       5'h0E, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
        run_op("TRUE",      5'h0F, 32'h12345678, 32'h9ABCDEF0, 32'h00000001, 1'b0, 1);

        run_op("MULH min*min", 5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33);
        run_op("MUL lo",       5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33);
        run_op("MULHU",        5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        run_op("MULHSU",       5'h13, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 33);
        run_op("MULH neg",     5'h11, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 1'b0, 33);
        run_op("MUL neg lo",   5'h10, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0, 33);

`ifdef ALU_MDU_DIV_EN
        run_op("DIV ovf",   5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34);
        run_op("REM by0",   5'h16, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 34);
        run_op("DIVU by0",  5'h15, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34);
        run_op("DIV neg",   5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 34);
        run_op("REM neg",   5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 34);
        run_op("REMU",      5'h17, 32'h00000007, 32'h00000002, 32'h00000001, 1'b0, 34);
        run_op("DIV by0 s", 5'h14, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34);
        flush_test("DIV", 5'h14);
`else
        run_op("DIV absent",  5'h14, 32'h00000007, 32'h00000002, 32'h00000000, 1'b1, 1);
        run_op("REMU absent", 5'h17, 32'h00000007, 32'h00000002, 32'h00000000, 1'b1, 1);
`endif
        flush_test("MUL", 5'h10);

        // Backpressure: result held while the consumer stalls
        issue(5'h02, 32'd1, 32'd2);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", bus.out_valid, 1);
            check("stall ALUResult", bus.ALUResult, 32'd3);
            check("stall in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_op("illegal 1A", 5'h1A, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1);
        run_op("illegal 1F", 5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1);

        // Flush in DONE drops the held result
        issue(5'h02, 32'd4, 32'd5);
        check("done before flush", bus.out_valid, 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush in DONE out_valid", bus.out_valid, 0);
        check("flush in DONE in_ready", bus.in_ready, 1);

        // Flush wins over a same-cycle request
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        bus.Operation = 5'h02;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        check("flush beats accept", bus.in_ready, 1);
        expect_silence("no result from flushed accept", 3);

        // Reset mid-multiply abandons the operation
        issue(5'h12, 32'hFFFFFFFF, 32'h00000003);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid reset out_valid", bus.out_valid, 0);
        check("mid reset ALUResult", bus.ALUResult, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready after mid reset", bus.in_ready, 1);
        expect_silence("no result after mid reset", 40);
        run_op("ADD after reset", 5'h02, 32'd10, 32'd20, 32'd30, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
